// File: rtl/sha2_msg_schedule.sv
// rtl/sha2_msg_schedule.sv - SHA-2 message schedule: 16-word block in, W_t/t stream out
// Optional build macro: SHA2_SCHED_ZEROIZE_EN clears the word buffer on the final handshake.
module sha2_msg_schedule #(
  parameter int WIDTH = 32,
  parameter int MODE  = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [16*WIDTH-1:0] block_in,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WIDTH-1:0]   W,
  output logic [6:0]         t,
  output logic               w_last
);

  localparam bit BIG    = (MODE == 384) || (MODE == 512);
  localparam int ROUNDS = BIG ? 80 : 64;
  localparam int S0A = BIG ? 1  : 7;
  localparam int S0B = BIG ? 8  : 18;
  localparam int S0C = BIG ? 7  : 3;
  localparam int S1A = BIG ? 19 : 17;
  localparam int S1B = BIG ? 61 : 19;
  localparam int S1C = BIG ? 6  : 10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wbuf [16];
  logic [6:0]       t_q;
  logic [WIDTH-1:0] next_word;
  logic             accept, fire;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] sigma0(input logic [WIDTH-1:0] x);
    return rotr(x, S0A) ^ rotr(x, S0B) ^ (x >> S0C);
  endfunction

  function automatic logic [WIDTH-1:0] sigma1(input logic [WIDTH-1:0] x);
    return rotr(x, S1A) ^ rotr(x, S1B) ^ (x >> S1C);
  endfunction

  // W_{t+16} from the current window; wraps modulo 2^WIDTH
  assign next_word = sigma1(wbuf[14]) + wbuf[9] + sigma0(wbuf[1]) + wbuf[0];

  assign W      = wbuf[0];
  assign t      = t_q;
  assign w_last = (state_q == RUN) && (t_q == 7'(ROUNDS - 1));
  assign accept = in_valid && in_ready;
  assign fire   = w_valid && w_ready;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    w_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        w_valid = 1'b1;
        if (w_ready && w_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) wbuf[i] <= '0;
      t_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) wbuf[i] <= block_in[(16-i)*WIDTH-1 -: WIDTH];
      t_q <= '0;
    end else if (fire) begin
      if (w_last) begin
        t_q <= '0;
`ifdef SHA2_SCHED_ZEROIZE_EN
        for (int i = 0; i < 16; i++) wbuf[i] <= '0;
`else
        for (int i = 0; i < 15; i++) wbuf[i] <= wbuf[i+1];
        wbuf[15] <= next_word;
`endif
      end else begin
        for (int i = 0; i < 15; i++) wbuf[i] <= wbuf[i+1];
        wbuf[15] <= next_word;
        t_q      <= t_q + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// tb/tb_sha2_msg_schedule.sv - randomized check of sha2_msg_schedule (MODE 256 and 512) against a software schedule
module tb_sha2_msg_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          w_ready = 1'b0;
  logic [511:0]  a_blk = '0;
  logic [1023:0] b_blk = '0;

  logic a_in_ready, a_w_valid, a_w_last, b_in_ready, b_w_valid, b_w_last;
  logic [31:0] a_W;
  logic [63:0] b_W;
  logic [6:0]  a_t, b_t;
  logic a_in_valid, b_in_valid, a_w_ready, b_w_ready;

  assign a_in_valid = in_valid && !sel;
  assign b_in_valid = in_valid && sel;
  assign a_w_ready  = w_ready && !sel;
  assign b_w_ready  = w_ready && sel;

  sha2_msg_schedule #(.WIDTH(32), .MODE(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .block_in(a_blk), .w_valid(a_w_valid), .w_ready(a_w_ready),
    .W(a_W), .t(a_t), .w_last(a_w_last));

  sha2_msg_schedule #(.WIDTH(64), .MODE(512)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .block_in(b_blk), .w_valid(b_w_valid), .w_ready(b_w_ready),
    .W(b_W), .t(b_t), .w_last(b_w_last));

  logic [63:0] cur_W;
  logic [6:0]  cur_t;
  logic        cur_wv, cur_wl, cur_ir;
  assign cur_W  = sel ? b_W : {32'b0, a_W};
  assign cur_t  = sel ? b_t : a_t;
  assign cur_wv = sel ? b_w_valid : a_w_valid;
  assign cur_wl = sel ? b_w_last : a_w_last;
  assign cur_ir = sel ? b_in_ready : a_in_ready;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] exp_w [81];
  logic [63:0] obs_w [81];
  logic [63:0] m_abc [16];
  logic [63:0] m1 [16];
  logic [63:0] m2 [16];

  function automatic logic [63:0] ror(input logic [63:0] x, input int n, input bit big);
    logic [63:0] d;
    if (big) return (x >> n) | (x << (64 - n));
    d = {x[31:0], x[31:0]};
    return (d >> n) & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input bit big);
    if (big) return ror(x, 1, 1) ^ ror(x, 8, 1) ^ (x >> 7);
    return ror(x, 7, 0) ^ ror(x, 18, 0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input bit big);
    if (big) return ror(x, 19, 1) ^ ror(x, 61, 1) ^ (x >> 6);
    return ror(x, 17, 0) ^ ror(x, 19, 0) ^ (x >> 10);
  endfunction

  // textbook W_t recurrence, one word beyond the last round for the idle-state check
  task automatic gen_exp(input logic [63:0] m [16]);
    logic [63:0] mask;
    mask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    for (int i = 0; i < 81; i++) begin
      if (i < 16) exp_w[i] = m[i] & mask;
      else exp_w[i] = (s1(exp_w[i-2], sel) + exp_w[i-7] + s0(exp_w[i-15], sel) + exp_w[i-16]) & mask;
    end
  endtask

  task automatic set_block(input logic [63:0] m [16]);
    for (int i = 0; i < 16; i++) begin
      a_blk[(16-i)*32-1 -: 32] = m[i][31:0];
      b_blk[(16-i)*64-1 -: 64] = m[i];
    end
  endtask

  task automatic rand_block(output logic [63:0] m [16]);
    for (int i = 0; i < 16; i++) m[i] = {$urandom, $urandom};
  endtask

  task automatic load();
    in_valid = 1'b1;
    check("load_in_ready", cur_ir, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // expects to be entered #1 after the load edge; consumes the block from exp_w
  task automatic stream(input int stall_pct, input bit hold, input int stop_at);
    int idx, rounds, cyc;
    bit rdy;
    rounds = sel ? 80 : 64;
    idx = 0;
    cyc = 0;
    while (idx < rounds && cyc < 2000) begin
      if (idx == stop_at) return;
      rdy = ($urandom_range(99) >= stall_pct);
      w_ready = rdy;
      check("w_valid", cur_wv, 1'b1);
      check("W", cur_W, exp_w[idx]);
      check("t", cur_t, idx);
      check("w_last", cur_wl, idx == rounds - 1);
      if (hold) check("in_ready_run", cur_ir, 1'b0);
      if (rdy) obs_w[idx] = cur_W;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    w_ready = 1'b0;
    check("words_done", idx, rounds);
    check("idle_w_valid", cur_wv, 1'b0);
    check("idle_in_ready", cur_ir, 1'b1);
    check("idle_w_last", cur_wl, 1'b0);
`ifdef SHA2_SCHED_ZEROIZE_EN
    check("idle_W_zero", cur_W, 64'd0);
`else
    check("idle_W_stale", cur_W, exp_w[rounds]);
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_abc[i] = '0;

    #12;
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_w_valid", a_w_valid, 1'b0);
    check("rst_W", a_W, 32'd0);
    check("rst_t", a_t, 7'd0);
    check("rst_w_last", a_w_last, 1'b0);
    check("rst_W_b", b_W, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SHA-256 "abc", no stalls
    sel = 1'b0;
    m_abc[0] = 64'h6162_6380; m_abc[15] = 64'h18;
    gen_exp(m_abc); set_block(m_abc);
    load(); stream(0, 0, -1);
    check("abc256_W0", obs_w[0], 64'h6162_6380);
    check("abc256_W16", obs_w[16], 64'h6162_6380);
    check("abc256_W17", obs_w[17], 64'h000F_0000);

    // same block with random stalls
    load(); stream(40, 0, -1);
    check("abc256_stall_W17", obs_w[17], 64'h000F_0000);

    // random block, second block held during RUN, back-to-back load
    for (int r = 0; r < 3; r++) begin
      rand_block(m1); rand_block(m2);
      gen_exp(m1); set_block(m1);
      load();
      set_block(m2); in_valid = 1'b1;
      stream(30, 1, -1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      gen_exp(m2);
      stream(20, 0, -1);
    end

    // SHA-512 "abc"
    sel = 1'b1;
    m_abc[0] = 64'h6162_6380_0000_0000; m_abc[15] = 64'h18;
    gen_exp(m_abc); set_block(m_abc);
    load(); stream(0, 0, -1);
    check("abc512_W16", obs_w[16], 64'h6162_6380_0000_0000);
    check("abc512_W17", obs_w[17], 64'h0003_0000_0000_00C0);
    rand_block(m1); gen_exp(m1); set_block(m1);
    load(); stream(35, 0, -1);

    // reset mid-block at t=30 then fresh start
    sel = 1'b0;
    rand_block(m1); gen_exp(m1); set_block(m1);
    load(); stream(0, 0, 30);
    w_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_in_ready", a_in_ready, 1'b1);
    check("mrst_w_valid", a_w_valid, 1'b0);
    check("mrst_W", a_W, 32'd0);
    check("mrst_t", a_t, 7'd0);
    check("mrst_w_last", a_w_last, 1'b0);
    w_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_block(m2); gen_exp(m2); set_block(m2);
    load(); stream(25, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
